// File: rtl/line_memory_responder_if.sv
// Petition/serviceReady memory bus between a line requester (master) and the responder (slave).
interface line_memory_responder_if #(
    parameter int unsigned cache_line_width = 256,
    parameter int unsigned addr_width       = 16
);
    logic                        petition;
    logic [addr_width-1:0]       address;
    logic                        we;
    logic [cache_line_width-1:0] data_write;
    logic                        serviceReady;
    logic [cache_line_width-1:0] data_read;
    logic                        wp_violation;

    modport master (
        output petition, address, we, data_write,
        input  serviceReady, data_read, wp_violation
    );

    modport slave (
        input  petition, address, we, data_write,
        output serviceReady, data_read, wp_violation
    );
endinterface

// File: rtl/line_memory_responder.sv
// Fixed-latency main memory serving one full cache line per petition.
// Define MEM_WP_EN to make lines 0..wp_lines-1 read-only (blocked writes pulse wp_violation).
module line_memory_responder #(
    parameter int unsigned cache_line_width = 256,
    parameter int unsigned addr_width       = 16,
    parameter int unsigned mem_lines        = 64,
    parameter int unsigned latency          = 5,
    parameter int unsigned wp_lines         = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    line_memory_responder_if.slave  bus
);
    localparam int unsigned OFF   = $clog2(cache_line_width / 8);
    localparam int unsigned IDX_W = $clog2(mem_lines);
    localparam int unsigned CNT_W = (latency > 1) ? $clog2(latency) : 1;

    if (latency < 1 || wp_lines > mem_lines || (cache_line_width % 8) != 0) begin : gBadParams
        $error("line_memory_responder: invalid parameter set");
    end

    typedef enum logic [1:0] {IDLE, BUSY, READY, COOL} state_t;

    state_t                      state;
    logic [CNT_W-1:0]            cnt;
    logic [IDX_W-1:0]            capIdx;
    logic                        capWe;
    logic [cache_line_width-1:0] capData;
    logic                        serviceReadyQ;
    logic [cache_line_width-1:0] dataReadQ;
    logic [cache_line_width-1:0] mem [mem_lines];

    logic [IDX_W-1:0] reqIdx_c;
    logic             accept_c;
    logic             commit_c;
    logic             blocked_c;
    logic             memWrite_c;

    // Upper address bits fall off the cast, giving the modulo-mem_lines wrap.
    assign reqIdx_c = IDX_W'(bus.address >> OFF);

    // The READY-cycle edge still sees the finished request's petition, so only IDLE/COOL accept.
    assign accept_c = bus.petition && (state == IDLE || state == COOL);
    assign commit_c = (state == BUSY) && (cnt == '0);

`ifdef MEM_WP_EN
    assign blocked_c = capWe && (32'(capIdx) < wp_lines);
`else
    assign blocked_c = 1'b0;
`endif

    assign memWrite_c = commit_c && capWe && !blocked_c && !reset;

    // Storage array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (memWrite_c) begin
            mem[capIdx] <= capData;
        end
    end

`ifdef MEM_WP_EN
    logic wpViolationQ;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            capIdx        <= '0;
            capWe         <= 1'b0;
            capData       <= '0;
            serviceReadyQ <= 1'b0;
            dataReadQ     <= '0;
`ifdef MEM_WP_EN
            wpViolationQ  <= 1'b0;
`endif
        end else begin
            serviceReadyQ <= 1'b0;
`ifdef MEM_WP_EN
            wpViolationQ  <= 1'b0;
`endif
            case (state)
                IDLE:    if (bus.petition) state <= BUSY;
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state         <= READY;
                        serviceReadyQ <= 1'b1;
                        dataReadQ     <= (capWe && !blocked_c) ? capData : mem[capIdx];
`ifdef MEM_WP_EN
                        wpViolationQ  <= blocked_c;
`endif
                    end
                end
                READY:   state <= COOL;
                COOL:    state <= bus.petition ? BUSY : IDLE;
                default: state <= IDLE;
            endcase

            if (accept_c) begin
                capIdx  <= reqIdx_c;
                capWe   <= bus.we;
                capData <= bus.data_write;
                cnt     <= CNT_W'(latency - 1);
            end
        end
    end

    assign bus.serviceReady = serviceReadyQ;
    assign bus.data_read    = dataReadQ;
`ifdef MEM_WP_EN
    assign bus.wp_violation = wpViolationQ;
`else
    assign bus.wp_violation = 1'b0;
`endif

endmodule
